// File: rtl/sdram_sched_pkg.sv
// Shared types and defaults for the SDRAM request scheduler.
package sdram_sched_pkg;

    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP
    } sched_state_t;

    typedef struct packed {
        logic                      we;
        logic [DEFAULT_DATA_W-1:0] data;
    } sdram_req_t;

endpackage

// File: rtl/sdram_req_scheduler_fifo.sv
// sync_fifo: single-clock FIFO with registered storage, head shown combinationally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_req_scheduler.sv
// Request FIFO, spaced command issue and in-order read return for sdram_controller.
// Optional SDRAM_SCHED_STATS_EN adds issue/stall statistics counters.
//
// state   | meaning
// S_IDLE  | waiting for a queued request with gap_cnt at 0
// S_ISSUE | one-cycle command on sd_* (head already popped)
// S_GAP   | gap_cnt counting down toward the next allowed issue
module sdram_req_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int DATA_W          = DEFAULT_DATA_W,
    parameter int REQ_DEPTH       = 8,
    parameter int CMD_GAP         = 4,
    parameter int RD_LATENCY      = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              sd_chip_sel,
    output logic              sd_wr_en,
    output logic              sd_rd_en,
    output logic [DATA_W-1:0] sd_data_in,
    input  logic [DATA_W-1:0] sd_data_out,
`ifdef SDRAM_SCHED_STATS_EN
    output logic [31:0]       stat_wr_cnt,
    output logic [31:0]       stat_rd_cnt,
    output logic [31:0]       stat_stall_cnt,
`endif
    output logic              idle
);

    localparam int GAP_W  = (CMD_GAP > 1) ? $clog2(CMD_GAP) : 1;
    localparam int CRD_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int REQ_CW = $clog2(REQ_DEPTH + 1);
    localparam int RSP_CW = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] data;
    } req_entry_t;

    sched_state_t      state, state_d;
    req_entry_t        req_wentry, req_head;
    logic              req_full, req_empty;
    logic [REQ_CW-1:0] req_count;
    logic              rsp_push, rsp_pop, rsp_full, rsp_empty;
    logic [RSP_CW-1:0] rsp_count;
    logic [GAP_W-1:0]  gap_cnt;
    logic [CRD_W-1:0]  credits;
    logic [RD_LATENCY-1:0] rd_pipe;
    logic              head_blocked, can_issue, issue_now, rd_issue;

    assign req_wentry = '{we: req_we, data: req_wdata};
    assign req_ready  = !req_full;

    sync_fifo #(.WIDTH($bits(req_entry_t)), .DEPTH(REQ_DEPTH)) u_req_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (req_valid),
        .wdata   (req_wentry),
        .pop     (issue_now),
        .rdata   (req_head),
        .full    (req_full),
        .empty   (req_empty),
        .count   (req_count)
    );

    // Credits bound the response FIFO occupancy, so rsp_full never gates a real push.
    assign rsp_push  = rd_pipe[RD_LATENCY-1] && !rsp_full;
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign rsp_valid = !rsp_empty;

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(MAX_OUTSTANDING)) u_rsp_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rsp_push),
        .wdata   (sd_data_out),
        .pop     (rsp_pop),
        .rdata   (rsp_data),
        .full    (rsp_full),
        .empty   (rsp_empty),
        .count   (rsp_count)
    );

    assign head_blocked = !req_empty && !req_head.we && (credits == CRD_W'(MAX_OUTSTANDING));
    assign can_issue    = !req_empty && (gap_cnt == '0) && !head_blocked;
    assign issue_now    = (state_d == S_ISSUE);
    assign rd_issue     = issue_now && !req_head.we;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (can_issue) state_d = S_ISSUE;
            S_ISSUE: begin
                if (CMD_GAP > 1)    state_d = S_GAP;
                else if (can_issue) state_d = S_ISSUE;
                else                state_d = S_IDLE;
            end
            S_GAP:   if (gap_cnt == '0) state_d = can_issue ? S_ISSUE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // gap_cnt already counts during the ISSUE cycle, giving exactly CMD_GAP between issues.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gap_cnt     <= '0;
            credits     <= '0;
            rd_pipe     <= '0;
            sd_chip_sel <= 1'b0;
            sd_wr_en    <= 1'b0;
            sd_rd_en    <= 1'b0;
            sd_data_in  <= '0;
        end else begin
            if (issue_now) begin
                gap_cnt <= GAP_W'(CMD_GAP - 1);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
            case ({rd_issue, rsp_pop})
                2'b10:   credits <= credits + 1'b1;
                2'b01:   credits <= credits - 1'b1;
                default: credits <= credits;
            endcase
            rd_pipe[0] <= sd_rd_en;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            sd_chip_sel <= issue_now;
            sd_wr_en    <= issue_now && req_head.we;
            sd_rd_en    <= rd_issue;
            sd_data_in  <= (issue_now && req_head.we) ? req_head.data : '0;
        end
    end

    assign idle = (req_count == '0) && (rd_pipe == '0) && (rsp_count == '0) && (state != S_ISSUE);

`ifdef SDRAM_SCHED_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_wr_cnt    <= '0;
            stat_rd_cnt    <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (issue_now && req_head.we) stat_wr_cnt <= stat_wr_cnt + 1'b1;
            if (rd_issue)                 stat_rd_cnt <= stat_rd_cnt + 1'b1;
            if (head_blocked && (gap_cnt == '0)) stat_stall_cnt <= stat_stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: doc/sdram_req_scheduler.md
Name: sdram_req_scheduler

Overview:
Upstream front-end for sdram_controller. Accepts write/read requests from the neural engine over a valid/ready handshake and buffers them in a request FIFO. Issues them to the controller's single-cycle wr_en/rd_en/chip_sel interface with a minimum command spacing. Captures read data after a fixed controller latency and returns it in order over a valid/ready response port.

Parameters:
DATA_W, 16, data width; matches the controller data_in/data_out.
REQ_DEPTH, 8, request FIFO entries (power of 2, >=2).
CMD_GAP, 4, minimum cycles between successive issued commands (>=1).
RD_LATENCY, 3, cycles from the rd_en issue cycle to valid sd_data_out (>=1).
MAX_OUTSTANDING, 4, read credits: reads in flight plus buffered responses; also the response FIFO depth.

Ports:
clk  in  1  single clock.
reset_n  in  1  asynchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  request FIFO not full.
req_we  in  1  1=write, 0=read.
req_wdata  in  DATA_W  write data; ignored for reads.
rsp_valid  out  1  read data available.
rsp_ready  in  1  consumer accepts read data.
rsp_data  out  DATA_W  read data, in request order.
sd_chip_sel  out  1  to controller chip_sel.
sd_wr_en  out  1  to controller wr_en.
sd_rd_en  out  1  to controller rd_en.
sd_data_in  out  DATA_W  to controller data_in.
sd_data_out  in  DATA_W  from controller data_out.
idle  out  1  no queued, in-flight or buffered work.

Behaviour:
- Reset (async assert, sync deassert): both FIFOs empty, gap counter 0, latency pipe clear, credits 0. All sd_* outputs 0, rsp_valid 0, req_ready 1, idle 1.
- Request push: occurs when req_valid && req_ready. req_ready = !full, with no same-cycle pop bypass. An entry is {we, wdata}.
- Scheduler FSM:
  - IDLE -> ISSUE when the FIFO is non-empty and gap_cnt==0.
  - ISSUE stalls if the head entry is a read and credits==MAX_OUTSTANDING. A stalled head blocks all later entries, including writes, so order is strict.
  - ISSUE is one cycle: sd_chip_sel=1; sd_wr_en=we, sd_rd_en=!we; sd_data_in=wdata for writes, 0 for reads. The head is popped and gap_cnt loads CMD_GAP-1.
  - ISSUE -> GAP if CMD_GAP>1, otherwise -> IDLE/ISSUE directly.
  - GAP decrements gap_cnt and returns to IDLE at 0.
  - Result: successive issues are separated by exactly CMD_GAP cycles when work is queued.
- Outside ISSUE, sd_* outputs are 0. These outputs are registered.
- Issue latency: a request accepted at an edge at cycle t issues at cycle t+1 at the earliest.
- Read return:
  - A read issue at cycle T sets bit 0 of a RD_LATENCY-deep valid shift pipe.
  - At cycle T+RD_LATENCY, sd_data_out is pushed into the response FIFO.
  - rsp_valid rises at T+RD_LATENCY+1. rsp_data is the FIFO head and holds stable while rsp_valid && !rsp_ready.
- Credits: +1 on read issue, -1 on response pop (rsp_valid && rsp_ready). A simultaneous issue and pop leaves credits unchanged. Credits never exceed MAX_OUTSTANDING, so the response FIFO cannot overflow.
- idle = request FIFO empty && pipe clear && response FIFO empty && FSM not in ISSUE.
- Reset mid-operation: all queued requests, in-flight reads and responses are discarded.

Optional Feature:
SDRAM_SCHED_STATS_EN
- Defined: adds outputs stat_wr_cnt[31:0], stat_rd_cnt[31:0] and stat_stall_cnt[31:0].
  - stat_wr_cnt and stat_rd_cnt increment on write and read issues.
  - stat_stall_cnt counts cycles in which the head is a read blocked by credits.
  - All three reset to 0 and wrap at 2^32.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package sdram_sched_pkg holds:
  - typedef sched_state_t {S_IDLE, S_ISSUE, S_GAP};
  - typedef sdram_req_t {logic we; logic [DATA_W-1:0] data};
  - the default DATA_W constant.
- Sub-module sync_fifo (parameterized WIDTH, DEPTH; push/pop/full/empty/count, registered storage) is instantiated twice: once for requests and once for responses.

Test Plan:
- Reset: assert reset_n=0 mid-activity -> next cycle all sd_* 0, rsp_valid 0, req_ready 1, idle 1.
- Single write: req_we=1, req_wdata=16'hBEEF accepted at cycle 0 -> cycle 1 sd_chip_sel=1, sd_wr_en=1, sd_data_in=16'hBEEF for exactly one cycle.
- Back-to-back writes: 3 writes pushed in cycles 0-2 with CMD_GAP=4 -> issues at cycles 1, 5, 9, with data order preserved.
- Read: read issued at cycle T, bench drives sd_data_out=16'h1234 at T+3 -> rsp_valid=1 with rsp_data=16'h1234 at T+4.
- Credit limit: rsp_ready=0 and 6 reads queued -> exactly 4 sd_rd_en pulses, then stall. Then rsp_ready=1 -> remaining 2 issue and all 6 responses return in order.
- Full FIFO: with rsp_ready=0 pre-loading 4 reads, push 8 more reads -> req_ready=0 after the 8th. A 9th req_valid is not accepted until an issue pops an entry.
